// File: rtl/reset_sequencer_if.sv
// PLL-side handshake of the reset sequencer: lock and soft request in,
// per-domain active-low resets and the all-released flag out.
interface reset_sequencer_if #(
  parameter int CHANNELS = 3
);
  logic                en;
  logic                soft_req;
  logic [CHANNELS-1:0] n_reset_out;
  logic                done;

  modport master (
    output en,
    output soft_req,
    input  n_reset_out,
    input  done
  );

  modport slave (
    input  en,
    input  soft_req,
    output n_reset_out,
    output done
  );
endinterface

// File: rtl/reset_sequencer.sv
// Waits for a filtered PLL lock, holds a startup delay, then releases CHANNELS
// active-low reset domains in order at a fixed stagger; re-sequences on lock loss or soft request.
module reset_sequencer #(
  parameter int CHANNELS       = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int LOCK_FILTER    = 4,
  parameter int STARTUP_CYCLES = 1024,
  parameter int STAGGER_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  reset_sequencer_if.slave  bus
);

  localparam int CNT_MAX = (STARTUP_CYCLES > STAGGER_CYCLES) ? STARTUP_CYCLES : STAGGER_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int FW      = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER + 1) : 1;

  localparam logic [CW-1:0]       START_LAST = CW'(STARTUP_CYCLES - 1);
  localparam logic [CW-1:0]       STAG_LAST  = CW'(STAGGER_CYCLES - 1);
  localparam logic [FW-1:0]       FILT_LAST  = FW'(LOCK_FILTER - 1);
  localparam logic [IW-1:0]       IDX_LAST   = IW'(CHANNELS - 1);
  localparam logic [CHANNELS-1:0] CH_ONE     = CHANNELS'(1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STARTUP   = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [FW-1:0]       filt_q, filt_d;
  logic [CHANNELS-1:0] n_q, n_d;
  logic                done_q, done_d;
  logic                en_s;
  logic                lock_lost_s;
  logic                soft_abort_s;

  assign sync_d       = {sync_q[SYNC_STAGES-2:0], bus.en};
  assign en_s         = sync_q[SYNC_STAGES-1];
  assign lock_lost_s  = (state_q != WAIT_LOCK) && !en_s;
  assign soft_abort_s = bus.soft_req && ((state_q == RELEASE) || (state_q == RUN));

  // Next state: lock loss beats soft request, which beats normal progression.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    filt_d  = filt_q;
    n_d     = n_q;
    done_d  = done_q;

    if (lock_lost_s) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      idx_d   = '0;
      filt_d  = '0;
      n_d     = '0;
      done_d  = 1'b0;
    end else if (soft_abort_s) begin
      state_d = STARTUP;
      cnt_d   = '0;
      idx_d   = '0;
      n_d     = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (!en_s) begin
            filt_d = '0;
          end else if (filt_q == FILT_LAST) begin
            filt_d  = '0;
            cnt_d   = '0;
            state_d = STARTUP;
          end else begin
            filt_d = filt_q + FW'(1);
          end
        end
        STARTUP: begin
          if (cnt_q == START_LAST) begin
            cnt_d = '0;
            n_d   = n_q | CH_ONE;
            idx_d = IW'(1);
            if (CHANNELS == 1) begin
              state_d = RUN;
              done_d  = 1'b1;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RELEASE: begin
          if (cnt_q == STAG_LAST) begin
            cnt_d = '0;
            n_d   = n_q | (CH_ONE << idx_q);
            if (idx_q == IDX_LAST) begin
              state_d = RUN;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          idx_d   = '0;
          filt_d  = '0;
          n_d     = '0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_LOCK;
      sync_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      filt_q  <= '0;
      n_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      filt_q  <= filt_d;
      n_q     <= n_d;
      done_q  <= done_d;
    end
  end

  assign bus.n_reset_out = n_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: per-edge expected outputs are queued
// with each scenario's stimulus and compared as the edges occur.
module tb_reset_sequencer;

  logic clk;
  logic reset;
  int   cyc;
  int   n_vec;
  int   n_bad;

  typedef struct {
    int         edge_no;
    logic [2:0] n;
    logic       d;
    string      tag;
  } exp_t;

  exp_t sb[$];

  reset_sequencer_if #(.CHANNELS(3)) bus();

  reset_sequencer #(
    .CHANNELS(3),
    .SYNC_STAGES(2),
    .LOCK_FILTER(4),
    .STARTUP_CYCLES(8),
    .STAGGER_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic exp_rng(input string tag, input int a, input int b, input logic [2:0] n, input logic d);
    for (int e = a; e <= b; e++) begin
      exp_t x;
      x.edge_no = e;
      x.n       = n;
      x.d       = d;
      x.tag     = tag;
      sb.push_back(x);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    while (sb.size() > 0 && sb[0].edge_no <= cyc) begin
      exp_t x;
      x = sb.pop_front();
      chk($sformatf("%s@%0d", x.tag, x.edge_no),
          {28'd0, bus.done, bus.n_reset_out}, {28'd0, x.d, x.n});
    end
  endtask

  task automatic do_reset(input string tag);
    reset        = 1'b1;
    bus.en       = 1'b0;
    bus.soft_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_rst"}, {28'd0, bus.done, bus.n_reset_out}, 32'd0);
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic drain(input string tag);
    chk({tag, "_drain"}, sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    cyc   = 0;

    // 1: nominal power-up
    do_reset("nom");
    exp_rng("nom", 1, 13, 3'b000, 1'b0);
    exp_rng("nom", 14, 17, 3'b001, 1'b0);
    exp_rng("nom", 18, 21, 3'b011, 1'b0);
    exp_rng("nom", 22, 30, 3'b111, 1'b1);
    for (int c = 1; c <= 30; c++) begin
      bus.en = 1'b1;
      tick();
    end
    drain("nom");

    // 2: lock glitch restarts the filter
    do_reset("glitch");
    exp_rng("glitch", 1, 17, 3'b000, 1'b0);
    exp_rng("glitch", 18, 21, 3'b001, 1'b0);
    exp_rng("glitch", 22, 25, 3'b011, 1'b0);
    exp_rng("glitch", 26, 30, 3'b111, 1'b1);
    for (int c = 1; c <= 30; c++) begin
      bus.en = (c != 4);
      tick();
    end
    drain("glitch");

    // 3: lock loss in RUN, then relock
    do_reset("loss");
    exp_rng("loss", 1, 13, 3'b000, 1'b0);
    exp_rng("loss", 14, 17, 3'b001, 1'b0);
    exp_rng("loss", 18, 21, 3'b011, 1'b0);
    exp_rng("loss", 22, 31, 3'b111, 1'b1);
    exp_rng("loss", 32, 47, 3'b000, 1'b0);
    exp_rng("loss", 48, 51, 3'b001, 1'b0);
    exp_rng("loss", 52, 55, 3'b011, 1'b0);
    exp_rng("loss", 56, 60, 3'b111, 1'b1);
    for (int c = 1; c <= 60; c++) begin
      bus.en = !(c >= 30 && c <= 34);
      tick();
    end
    drain("loss");

    // 4: soft request during RELEASE
    do_reset("soft");
    exp_rng("soft", 1, 13, 3'b000, 1'b0);
    exp_rng("soft", 14, 17, 3'b001, 1'b0);
    exp_rng("soft", 18, 18, 3'b011, 1'b0);
    exp_rng("soft", 19, 26, 3'b000, 1'b0);
    exp_rng("soft", 27, 30, 3'b001, 1'b0);
    exp_rng("soft", 31, 34, 3'b011, 1'b0);
    exp_rng("soft", 35, 40, 3'b111, 1'b1);
    for (int c = 1; c <= 40; c++) begin
      bus.en       = 1'b1;
      bus.soft_req = (c == 19);
      tick();
    end
    bus.soft_req = 1'b0;
    drain("soft");

    // 5: soft request and lock loss on the same edge
    do_reset("both");
    exp_rng("both", 1, 13, 3'b000, 1'b0);
    exp_rng("both", 14, 17, 3'b001, 1'b0);
    exp_rng("both", 18, 21, 3'b011, 1'b0);
    exp_rng("both", 22, 31, 3'b111, 1'b1);
    exp_rng("both", 32, 132, 3'b000, 1'b0);
    for (int c = 1; c <= 132; c++) begin
      bus.en       = (c < 30);
      bus.soft_req = (c == 32);
      tick();
    end
    bus.soft_req = 1'b0;
    drain("both");

    // 6: one-cycle reset in the middle of the sequence
    do_reset("mid");
    exp_rng("mid", 1, 13, 3'b000, 1'b0);
    exp_rng("mid", 14, 15, 3'b001, 1'b0);
    exp_rng("mid", 16, 29, 3'b000, 1'b0);
    exp_rng("mid", 30, 33, 3'b001, 1'b0);
    exp_rng("mid", 34, 37, 3'b011, 1'b0);
    exp_rng("mid", 38, 45, 3'b111, 1'b1);
    for (int c = 1; c <= 45; c++) begin
      bus.en = 1'b1;
      reset  = (c == 16);
      tick();
    end
    reset = 1'b0;
    drain("mid");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
